// File: rtl/jericalla_pkg.sv
// jericalla_pkg: shared state enum, instruction field layout and instruction struct
package jericalla_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, WRITE} state_t;

    localparam int INSTR_W  = 18;
    localparam int DP_W     = 17;
    localparam int FIELD_W  = 4;
    localparam int COND_BIT = 17;
    localparam int EN_BIT   = 16;
    localparam int DIR1_LSB = 12;
    localparam int DIR2_LSB = 8;
    localparam int OP_LSB   = 4;
    localparam int DIRR_LSB = 0;

    typedef struct packed {
        logic               cond;
        logic               en;
        logic [FIELD_W-1:0] dir1;
        logic [FIELD_W-1:0] dir2;
        logic [FIELD_W-1:0] op;
        logic [FIELD_W-1:0] dir_r;
    } instr_t;

endpackage

// File: rtl/jericalla_seq_fifo.sv
// jericalla_seq_fifo: instruction FIFO with wrap-around pointers and occupancy counter
module jericalla_seq_fifo
    import jericalla_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  instr_t wdata,
    output instr_t rdata,
    output logic   full,
    output logic   empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    instr_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    assign rdata = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

    // storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/jericalla_seq.sv
// jericalla_seq: instruction sequencer driving a ROM/ALU/RAM datapath; define JERICALLA_SEQ_COND_EN for conditional execution
module jericalla_seq
    import jericalla_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [INSTR_W-1:0] s_data,
    output logic [DP_W-1:0]    dp_in,
    input  logic [31:0]        dp_out,
    input  logic               dp_zf,
    output logic               res_valid,
    output logic [31:0]        res_data,
    output logic               res_zf,
    output logic               busy,
    output logic [15:0]        retired
);
`ifdef JERICALLA_SEQ_COND_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    state_t     state;
    instr_t     head;
    logic       full;
    logic       empty;
    logic       pop;
    logic       en_q;
    logic       cond_q;
    logic       skip_q;
    logic       zf_q;
    logic [3:0] cnt;

    assign s_ready = ~full & ~rst;
    assign pop     = ~empty & (state == IDLE || state == WRITE);
    assign busy    = state != IDLE;

    jericalla_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid & s_ready),
        .pop   (pop),
        .wdata (instr_t'(s_data)),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // sequencer FSM with registered datapath drive, flag capture and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dp_in     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zf    <= 1'b0;
            zf_q      <= 1'b0;
            retired   <= '0;
            cnt       <= '0;
            en_q      <= 1'b0;
            cond_q    <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state       <= LOAD;
                        dp_in       <= {1'b0, head.dir1, head.dir2, head.op, head.dir_r};
                        en_q        <= head.en;
                        cond_q      <= head.cond;
                    end
                end
                LOAD: begin
                    state  <= EXEC;
                    cnt    <= '0;
                    skip_q <= COND_EN & cond_q & ~zf_q;
                end
                EXEC: begin
                    if (cnt == 4'(SETTLE - 1)) begin
                        state         <= WRITE;
                        zf_q          <= dp_zf;
                        res_zf        <= dp_zf;
                        dp_in[EN_BIT] <= en_q & ~skip_q;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WRITE: begin
                    res_valid     <= 1'b1;
                    res_data      <= dp_out;
                    retired       <= retired + 16'd1;
                    dp_in[EN_BIT] <= 1'b0;
                    if (!empty) begin
                        state       <= LOAD;
                        dp_in[15:0] <= {head.dir1, head.dir2, head.op, head.dir_r};
                        en_q        <= head.en;
                        cond_q      <= head.cond;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jericalla_seq.sv
// tb_jericalla_seq: directed self-checking bench for jericalla_seq (SETTLE=1 and SETTLE=3 instances)
module tb_jericalla_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0, s_ready;
    logic [17:0] s_data = '0;
    logic [16:0] dp_in;
    logic [31:0] dp_out = '0;
    logic        dp_zf = 1'b0;
    logic        res_valid, res_zf, busy;
    logic [31:0] res_data;
    logic [15:0] retired;

    logic        s_valid3 = 1'b0, s_ready3;
    logic [17:0] s_data3 = '0;
    logic [16:0] dp_in3;
    logic [31:0] dp_out3;
    logic        res_valid3, res_zf3, busy3;
    logic [31:0] res_data3;
    logic [15:0] retired3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // free-running cycle counter for spacing measurements
    always @(posedge clk) cyc <= cyc + 1;

    assign dp_out3 = {15'd0, dp_in3};

    jericalla_seq #(.DEPTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .dp_in(dp_in), .dp_out(dp_out), .dp_zf(dp_zf), .res_valid(res_valid),
        .res_data(res_data), .res_zf(res_zf), .busy(busy), .retired(retired)
    );

    jericalla_seq #(.DEPTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
        .dp_in(dp_in3), .dp_out(dp_out3), .dp_zf(1'b0), .res_valid(res_valid3),
        .res_data(res_data3), .res_zf(res_zf3), .busy(busy3), .retired(retired3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [17:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_rv(input int lim, output logic got, output logic en_seen);
        got = 1'b0;
        en_seen = 1'b0;
        for (int t = 0; t < lim && !got; t++) begin
            @(negedge clk);
            en_seen = en_seen | dp_in[16];
            got = res_valid;
        end
    endtask

    initial begin
        logic        got, en_seen, seen;
        logic [17:0] stream [5];
        int          last, t;

        // reset values
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp_in", 32'(dp_in), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_zf", 32'(res_zf), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        rst = 1'b0;
        #1;
        chk("release_s_ready", 32'(s_ready), 32'd1);

        // single instruction 0x12354, SETTLE=1
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 18'h12354;
        dp_zf   = 1'b1;
        dp_out  = 32'hA5A5_0001;
        @(negedge clk);
        s_valid = 1'b0;
        chk("single_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("single_load_dp", 32'(dp_in), 32'h02354);
        chk("single_load_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("single_exec_dp", 32'(dp_in), 32'h02354);
        @(negedge clk);
        chk("single_write_dp", 32'(dp_in), 32'h12354);
        chk("single_write_rv", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("single_rv", 32'(res_valid), 32'd1);
        chk("single_res_data", res_data, 32'hA5A5_0001);
        chk("single_res_zf", 32'(res_zf), 32'd1);
        chk("single_retired", 32'(retired), 32'd1);
        chk("single_en_low", 32'(dp_in[16]), 32'd0);
        chk("single_busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("single_rv_pulse", 32'(res_valid), 32'd0);

        // retired counter wrap
        force dut.retired = 16'hFFFF;
        @(negedge clk);
        release dut.retired;
        chk("wrap_preload", 32'(retired), 32'h0000_FFFF);
        push1(18'h00001);
        wait_rv(20, got, en_seen);
        chk("wrap_rv", 32'(got), 32'd1);
        chk("wrap_retired", 32'(retired), 32'd0);

        // conditional instruction after a zero flag of 0
        dp_zf = 1'b0;
        push1(18'h00ABC);
        wait_rv(20, got, en_seen);
        chk("cond_pre_rv", 32'(got), 32'd1);
        chk("cond_pre_zf", 32'(res_zf), 32'd0);
        push1(18'h30DEF);
        wait_rv(20, got, en_seen);
        chk("cond_rv", 32'(got), 32'd1);
`ifdef JERICALLA_SEQ_COND_EN
        chk("cond_en_suppressed", 32'(en_seen), 32'd0);
`else
        chk("cond_en_ignored", 32'(en_seen), 32'd1);
`endif
        chk("cond_retired", 32'(retired), 32'd2);

        // reset asserted during EXEC aborts the instruction
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 18'h1FFFF;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_dp_in", 32'(dp_in), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_retired", 32'(retired), 32'd0);
        chk("abort_res_zf", 32'(res_zf), 32'd0);
        chk("abort_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | dp_in[16] | res_valid;
        end
        chk("abort_no_pulse", 32'(seen), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        // SETTLE=3: fill the FIFO behind a running instruction, stream retires
        stream[0] = 18'h0A111;
        stream[1] = 18'h1B222;
        stream[2] = 18'h0C333;
        stream[3] = 18'h1D444;
        stream[4] = 18'h0E555;
        @(negedge clk);
        s_valid3 = 1'b1;
        s_data3  = stream[0];
        @(negedge clk);
        s_valid3 = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            chk("fill_s_ready", 32'(s_ready3), 32'd1);
            s_valid3 = 1'b1;
            s_data3  = stream[k];
        end
        @(negedge clk);
        chk("full_s_ready", 32'(s_ready3), 32'd0);
        s_data3 = 18'h1F0F0;
        @(negedge clk);
        s_valid3 = 1'b0;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            t = 0;
            while (!res_valid3 && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk("stream_rv", 32'(res_valid3), 32'd1);
            chk("stream_order", res_data3, {15'd0, stream[k][16:0]});
            if (k > 0) chk("stream_spacing", 32'(cyc - last), 32'd5);
            last = cyc;
            @(negedge clk);
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | res_valid3;
        end
        chk("stream_no_extra", 32'(seen), 32'd0);
        chk("stream_retired", 32'(retired3), 32'd5);
        chk("stream_idle", 32'(busy3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
